// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, cause codes, enums and the control bundle for the decode stage
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam int CAUSE_MAX_W = 8;
  localparam logic [CAUSE_MAX_W-1:0] CAUSE_ILLEGAL = 8'd2;
  localparam logic [CAUSE_MAX_W-1:0] CAUSE_EBREAK  = 8'd3;
  localparam logic [CAUSE_MAX_W-1:0] CAUSE_ECALL   = 8'd11;

  typedef enum logic [2:0] {
    IMM_U = 3'd0,
    IMM_I = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_S = 3'd4,
    IMM_Z = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC4 = 2'd1,
    WB_CSR = 2'd2,
    WB_CMP = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    MUXA_RS1  = 2'd0,
    MUXA_PC   = 2'd1,
    MUXA_ZERO = 2'd2
  } muxa_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MDU_WAIT  = 2'd1,
    ST_TRAP_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]             alu_op;
    muxa_e                  muxa;
    logic                   muxb;
    logic                   muxcsr;
    imm_type_e              imm_type;
    logic                   we_mem;
    logic                   is_ls;
    logic                   data_or_alu;
    logic                   we_wb;
    logic [2:0]             funct3_mem;
    wb_sel_e                wb_sel;
    logic [1:0]             csr_op;
    logic                   is_csr;
    logic                   is_mret;
    logic                   is_mdu;
    logic                   is_branch;
    logic                   is_jal;
    logic                   is_jalr;
    logic [2:0]             br_cond;
    logic                   cmp_unsigned;
    logic                   trap;
    logic [CAUSE_MAX_W-1:0] cause;
  } ctrl_bundle_t;

endpackage

// File: rtl/rv_decoder.sv
// rtl/rv_decoder.sv - combinational RV32I(+M, +Zicsr) instruction to control bundle decoder
module rv_decoder
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.imm_type = IMM_U;
        ctrl.muxa     = MUXA_ZERO;
        ctrl.muxb     = 1'b1;
        ctrl.we_wb    = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_type = IMM_U;
        ctrl.muxa     = MUXA_PC;
        ctrl.muxb     = 1'b1;
        ctrl.we_wb    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.is_jal   = 1'b1;
        ctrl.imm_type = IMM_J;
        ctrl.muxa     = MUXA_PC;
        ctrl.muxb     = 1'b1;
        ctrl.we_wb    = 1'b1;
        ctrl.wb_sel   = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.is_jalr  = 1'b1;
        ctrl.imm_type = IMM_I;
        ctrl.muxb     = 1'b1;
        ctrl.we_wb    = 1'b1;
        ctrl.wb_sel   = WB_PC4;
      end
      OPC_BRANCH: begin
        // the ALU forms the target; EX resolves the condition from br_cond
        illegal        = (funct3[2:1] == 2'b01);
        ctrl.is_branch = 1'b1;
        ctrl.br_cond   = funct3;
        ctrl.imm_type  = IMM_B;
        ctrl.muxa      = MUXA_PC;
        ctrl.muxb      = 1'b1;
      end
      OPC_LOAD: begin
        illegal          = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        ctrl.is_ls       = 1'b1;
        ctrl.data_or_alu = 1'b1;
        ctrl.we_wb       = 1'b1;
        ctrl.imm_type    = IMM_I;
        ctrl.muxb        = 1'b1;
        ctrl.funct3_mem  = funct3;
      end
      OPC_STORE: begin
        illegal         = (funct3 > 3'd2);
        ctrl.is_ls      = 1'b1;
        ctrl.we_mem     = 1'b1;
        ctrl.imm_type   = IMM_S;
        ctrl.muxb       = 1'b1;
        ctrl.funct3_mem = funct3;
      end
      OPC_OP_IMM: begin
        ctrl.imm_type = IMM_I;
        ctrl.muxb     = 1'b1;
        ctrl.we_wb    = 1'b1;
        ctrl.alu_op   = {1'b0, funct3};
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
          ctrl.alu_op[3] = instr[30];
        end
        if (funct3 == 3'b010 || funct3 == 3'b011) ctrl.wb_sel = WB_CMP;
        ctrl.cmp_unsigned = (funct3 == 3'b011);
      end
      OPC_OP: begin
        ctrl.we_wb = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (ENABLE_M) begin
            ctrl.is_mdu = 1'b1;
            ctrl.alu_op = {1'b0, funct3};
          end else begin
            illegal = 1'b1;
          end
        end else begin
          ctrl.alu_op = {instr[30], funct3};
          if (funct7 == 7'b0100000) begin
            if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
          end else if (funct7 != 7'b0000000) begin
            illegal = 1'b1;
          end
          if (funct3 == 3'b010 || funct3 == 3'b011) ctrl.wb_sel = WB_CMP;
          ctrl.cmp_unsigned = (funct3 == 3'b011);
        end
      end
      OPC_MISC_MEM: begin
        ctrl = '0;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          if (instr == 32'h0000_0073) begin
            ctrl.trap  = 1'b1;
            ctrl.cause = CAUSE_ECALL;
          end else if (instr == 32'h0010_0073) begin
            ctrl.trap  = 1'b1;
            ctrl.cause = CAUSE_EBREAK;
          end else if (instr == 32'h3020_0073 && ENABLE_ZICSR) begin
            ctrl.is_mret = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'b100 || !ENABLE_ZICSR) begin
          illegal = 1'b1;
        end else begin
          ctrl.is_csr   = 1'b1;
          ctrl.csr_op   = instr[13:12];
          ctrl.muxcsr   = instr[14];
          ctrl.imm_type = instr[14] ? IMM_Z : IMM_I;
          ctrl.we_wb    = 1'b1;
          ctrl.wb_sel   = WB_CSR;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal || instr == 32'h0) begin
      ctrl       = '0;
      ctrl.trap  = 1'b1;
      ctrl.cause = CAUSE_ILLEGAL;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered ID stage: decode, valid/ready output register, issue-hold FSM
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1,
  parameter int CAUSE_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instr_i,
  input  logic [31:0]        pc_i,
  input  logic               flush_i,
  input  logic               mdu_done_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        pc_o,
  output logic [3:0]         alu_op_o,
  output logic [1:0]         muxa_o,
  output logic               muxb_o,
  output logic               muxcsr_o,
  output logic [2:0]         imm_type_o,
  output logic               we_mem_o,
  output logic               is_ls_o,
  output logic               data_or_alu_o,
  output logic               we_wb_o,
  output logic [2:0]         funct3_mem_o,
  output logic [1:0]         wb_sel_o,
  output logic [1:0]         csr_op_o,
  output logic               is_csr_o,
  output logic               is_mret_o,
  output logic               is_mdu_o,
  output logic               is_branch_o,
  output logic               is_jal_o,
  output logic               is_jalr_o,
  output logic [2:0]         br_cond_o,
  output logic               cmp_unsigned_o,
  output logic               trap_o,
  output logic [CAUSE_W-1:0] cause_o
);

  state_e       state, state_next;
  ctrl_bundle_t dec, held;
  logic [31:0]  pc_q;
  logic         valid_q;
  logic         accept;
  logic         transfer;

  rv_decoder #(
    .ENABLE_M     (ENABLE_M),
    .ENABLE_ZICSR (ENABLE_ZICSR)
  ) u_dec (
    .instr (instr_i),
    .ctrl  (dec)
  );

  assign in_ready_o = (state == ST_RUN) & ~flush_i & (~valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign transfer   = valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_RUN;
      valid_q <= 1'b0;
      held    <= '0;
      pc_q    <= '0;
    end else begin
      state <= state_next;
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        held    <= dec;
        pc_q    <= pc_i;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        // a trap accepted alongside an MDU transfer wins: only a flush releases it
        if (!flush_i) begin
          if (accept && dec.trap) state_next = ST_TRAP_HOLD;
          else if (transfer && held.is_mdu) state_next = ST_MDU_WAIT;
        end
      end
      ST_MDU_WAIT:  if (flush_i || mdu_done_i) state_next = ST_RUN;
      ST_TRAP_HOLD: if (flush_i) state_next = ST_RUN;
      default:      state_next = ST_RUN;
    endcase
  end

  assign out_valid_o    = valid_q;
  assign pc_o           = pc_q;
  assign alu_op_o       = held.alu_op;
  assign muxa_o         = held.muxa;
  assign muxb_o         = held.muxb;
  assign muxcsr_o       = held.muxcsr;
  assign imm_type_o     = held.imm_type;
  assign we_mem_o       = held.we_mem;
  assign is_ls_o        = held.is_ls;
  assign data_or_alu_o  = held.data_or_alu;
  assign we_wb_o        = held.we_wb;
  assign funct3_mem_o   = held.funct3_mem;
  assign wb_sel_o       = held.wb_sel;
  assign csr_op_o       = held.csr_op;
  assign is_csr_o       = held.is_csr;
  assign is_mret_o      = held.is_mret;
  assign is_mdu_o       = held.is_mdu;
  assign is_branch_o    = held.is_branch;
  assign is_jal_o       = held.is_jal;
  assign is_jalr_o      = held.is_jalr;
  assign br_cond_o      = held.br_cond;
  assign cmp_unsigned_o = held.cmp_unsigned;
  assign trap_o         = held.trap;

  generate
    if (CAUSE_W <= CAUSE_MAX_W) begin : g_cause_narrow
      assign cause_o = held.cause[CAUSE_W-1:0];
    end else begin : g_cause_wide
      assign cause_o = {{(CAUSE_W-CAUSE_MAX_W){1'b0}}, held.cause};
    end
  endgenerate

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - directed scoreboard bench for ctrl_decode_stage
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  muxa;
    logic        muxb;
    logic        muxcsr;
    logic [2:0]  imm_type;
    logic        we_mem;
    logic        is_ls;
    logic        data_or_alu;
    logic        we_wb;
    logic [2:0]  funct3_mem;
    logic [1:0]  wb_sel;
    logic [1:0]  csr_op;
    logic        is_csr;
    logic        is_mret;
    logic        is_mdu;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  br_cond;
    logic        cmp_unsigned;
    logic        trap;
    logic [3:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        mdu_done = 1'b0;
  logic        out_ready = 1'b0;

  logic in_ready, out_valid, muxb, muxcsr, we_mem, is_ls, data_or_alu, we_wb;
  logic is_csr, is_mret, is_mdu, is_branch, is_jal, is_jalr, cmp_unsigned, trap;
  logic [31:0] pc_out;
  logic [3:0]  alu_op, cause;
  logic [2:0]  imm_type, funct3_mem, br_cond;
  logic [1:0]  muxa, wb_sel, csr_op;

  logic n_in_ready, n_out_valid, n_muxb, n_muxcsr, n_we_mem, n_is_ls, n_data_or_alu, n_we_wb;
  logic n_is_csr, n_is_mret, n_is_mdu, n_is_branch, n_is_jal, n_is_jalr, n_cmp_unsigned, n_trap;
  logic [31:0] n_pc_out;
  logic [3:0]  n_alu_op, n_cause;
  logic [2:0]  n_imm_type, n_funct3_mem, n_br_cond;
  logic [1:0]  n_muxa, n_wb_sel, n_csr_op;

  exp_t obs, n_obs;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc_in), .flush_i(flush), .mdu_done_i(mdu_done),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out), .alu_op_o(alu_op),
    .muxa_o(muxa), .muxb_o(muxb), .muxcsr_o(muxcsr), .imm_type_o(imm_type),
    .we_mem_o(we_mem), .is_ls_o(is_ls), .data_or_alu_o(data_or_alu), .we_wb_o(we_wb),
    .funct3_mem_o(funct3_mem), .wb_sel_o(wb_sel), .csr_op_o(csr_op), .is_csr_o(is_csr),
    .is_mret_o(is_mret), .is_mdu_o(is_mdu), .is_branch_o(is_branch), .is_jal_o(is_jal),
    .is_jalr_o(is_jalr), .br_cond_o(br_cond), .cmp_unsigned_o(cmp_unsigned),
    .trap_o(trap), .cause_o(cause)
  );

  ctrl_decode_stage #(.ENABLE_M(1'b0)) dut_nom (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .instr_i(instr), .pc_i(pc_in), .flush_i(flush), .mdu_done_i(mdu_done),
    .out_valid_o(n_out_valid), .out_ready_i(out_ready), .pc_o(n_pc_out), .alu_op_o(n_alu_op),
    .muxa_o(n_muxa), .muxb_o(n_muxb), .muxcsr_o(n_muxcsr), .imm_type_o(n_imm_type),
    .we_mem_o(n_we_mem), .is_ls_o(n_is_ls), .data_or_alu_o(n_data_or_alu), .we_wb_o(n_we_wb),
    .funct3_mem_o(n_funct3_mem), .wb_sel_o(n_wb_sel), .csr_op_o(n_csr_op), .is_csr_o(n_is_csr),
    .is_mret_o(n_is_mret), .is_mdu_o(n_is_mdu), .is_branch_o(n_is_branch), .is_jal_o(n_is_jal),
    .is_jalr_o(n_is_jalr), .br_cond_o(n_br_cond), .cmp_unsigned_o(n_cmp_unsigned),
    .trap_o(n_trap), .cause_o(n_cause)
  );

  always_comb begin
    obs = '{pc: pc_out, alu_op: alu_op, muxa: muxa, muxb: muxb, muxcsr: muxcsr,
            imm_type: imm_type, we_mem: we_mem, is_ls: is_ls, data_or_alu: data_or_alu,
            we_wb: we_wb, funct3_mem: funct3_mem, wb_sel: wb_sel, csr_op: csr_op,
            is_csr: is_csr, is_mret: is_mret, is_mdu: is_mdu, is_branch: is_branch,
            is_jal: is_jal, is_jalr: is_jalr, br_cond: br_cond, cmp_unsigned: cmp_unsigned,
            trap: trap, cause: cause};
    n_obs = '{pc: n_pc_out, alu_op: n_alu_op, muxa: n_muxa, muxb: n_muxb, muxcsr: n_muxcsr,
              imm_type: n_imm_type, we_mem: n_we_mem, is_ls: n_is_ls, data_or_alu: n_data_or_alu,
              we_wb: n_we_wb, funct3_mem: n_funct3_mem, wb_sel: n_wb_sel, csr_op: n_csr_op,
              is_csr: n_is_csr, is_mret: n_is_mret, is_mdu: n_is_mdu, is_branch: n_is_branch,
              is_jal: n_is_jal, is_jalr: n_is_jalr, br_cond: n_br_cond, cmp_unsigned: n_cmp_unsigned,
              trap: n_trap, cause: n_cause};
  end

  task automatic chk(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // drive one word, wait (bounded) for ready, record expectation, let the edge take it
  task automatic send(input string tag, input logic [31:0] w, input logic [31:0] p, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr    = w;
    pc_in    = p;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({"accept_", tag}, in_ready, 1'b1);
    if (in_ready) sb.push_back(e);
    cyc();
    in_valid = 1'b0;
    instr    = '0;
    pc_in    = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  // scoreboard: every transfer to EX must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_spurious observed=bundle pc %0h expected=no bundle", pc_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (obs === e) else begin
          failures++;
          $error("FAIL sb_bundle observed=%h expected=%h", obs, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t e2;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    neg();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_bundle", obs, '0);
    chk("reset_nom_ready", n_in_ready, 1'b1);
    cyc();

    // addi x1,x0,5
    out_ready = 1'b1;
    e = '0; e.pc = 32'h100; e.muxb = 1'b1; e.imm_type = 3'd1; e.we_wb = 1'b1;
    send("addi", 32'h0050_0093, 32'h100, e);
    neg();
    chk("addi_out_valid", out_valid, 1'b1);
    chk("addi_imm_type", imm_type, 3'd1);
    cyc();

    // sub then add with EX stalled two cycles
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h4020_8033; pc_in = 32'h104;
    neg();
    chk("sub_ready", in_ready, 1'b1);
    e = '0; e.pc = 32'h104; e.alu_op = 4'd8; e.we_wb = 1'b1;
    sb.push_back(e);
    cyc();
    instr = 32'h0020_80B3; pc_in = 32'h108;
    neg();
    chk("stall1_valid", out_valid, 1'b1);
    chk("stall1_alu_op", alu_op, 4'd8);
    chk("stall1_ready", in_ready, 1'b0);
    cyc();
    neg();
    chk("stall2_alu_op", alu_op, 4'd8);
    chk("stall2_pc", pc_out, 32'h104);
    chk("stall2_ready", in_ready, 1'b0);
    cyc();
    out_ready = 1'b1;
    neg();
    chk("add_ready", in_ready, 1'b1);
    e = '0; e.pc = 32'h108; e.we_wb = 1'b1;
    sb.push_back(e);
    cyc();
    in_valid = 1'b0; instr = '0; pc_in = '0;
    neg();
    chk("add_alu_op", alu_op, 4'd0);
    chk("add_valid", out_valid, 1'b1);
    cyc();
    neg();
    chk("drain_valid", out_valid, 1'b0);
    cyc();

    // mul: MDU bubble on the M build, illegal trap on the no-M build
    e = '0; e.pc = 32'h10C; e.we_wb = 1'b1; e.is_mdu = 1'b1;
    send("mul", 32'h0220_81B3, 32'h10C, e);
    neg();
    chk("mul_is_mdu", is_mdu, 1'b1);
    e2 = '0; e2.pc = 32'h10C; e2.trap = 1'b1; e2.cause = 4'd2;
    chk("nom_trap_bundle", n_obs, e2);
    chk("nom_trap_hold", n_in_ready, 1'b0);
    cyc();
    neg();
    chk("mdu_bubble1", in_ready, 1'b0);
    cyc();
    neg();
    chk("mdu_bubble2", in_ready, 1'b0);
    cyc();
    mdu_done = 1'b1;
    neg();
    chk("mdu_done_cycle", in_ready, 1'b0);
    cyc();
    mdu_done = 1'b0;
    neg();
    chk("mdu_release", in_ready, 1'b1);
    chk("nom_ignores_done", n_in_ready, 1'b0);
    cyc();
    do_flush();
    neg();
    chk("nom_release", n_in_ready, 1'b1);
    cyc();

    // ecall / ebreak hold issue until flushed
    e = '0; e.pc = 32'h110; e.trap = 1'b1; e.cause = 4'd11;
    send("ecall", 32'h0000_0073, 32'h110, e);
    neg();
    chk("ecall_hold", in_ready, 1'b0);
    cyc();
    neg();
    chk("ecall_hold_drained", in_ready, 1'b0);
    chk("ecall_drained", out_valid, 1'b0);
    cyc();
    do_flush();
    e = '0; e.pc = 32'h114; e.trap = 1'b1; e.cause = 4'd3;
    send("ebreak", 32'h0010_0073, 32'h114, e);
    cyc();
    do_flush();

    // back-to-back legal words at full throughput
    e = '0; e.pc = 32'h118; e.is_mret = 1'b1;
    send("mret", 32'h3020_0073, 32'h118, e);
    e = '0; e.pc = 32'h11C; e.is_branch = 1'b1; e.br_cond = 3'd7; e.imm_type = 3'd2;
    e.muxa = 2'd1; e.muxb = 1'b1;
    send("bgeu", 32'h0020_F463, 32'h11C, e);
    e = '0; e.pc = 32'h120; e.is_ls = 1'b1; e.data_or_alu = 1'b1; e.we_wb = 1'b1;
    e.imm_type = 3'd1; e.muxb = 1'b1; e.funct3_mem = 3'd2;
    send("lw", 32'h0000_A103, 32'h120, e);
    e = '0; e.pc = 32'h124; e.is_ls = 1'b1; e.we_mem = 1'b1; e.imm_type = 3'd4;
    e.muxb = 1'b1; e.funct3_mem = 3'd2;
    send("sw", 32'h0020_A023, 32'h124, e);
    e = '0; e.pc = 32'h128; e.is_csr = 1'b1; e.csr_op = 2'd1; e.imm_type = 3'd1;
    e.we_wb = 1'b1; e.wb_sel = 2'd2;
    send("csrrw", 32'h3401_1073, 32'h128, e);
    e = '0; e.pc = 32'h12C; e.is_csr = 1'b1; e.csr_op = 2'd2; e.muxcsr = 1'b1;
    e.imm_type = 3'd5; e.we_wb = 1'b1; e.wb_sel = 2'd2;
    send("csrrsi", 32'h3400_E073, 32'h12C, e);
    e = '0; e.pc = 32'h130; e.alu_op = 4'd3; e.muxb = 1'b1; e.imm_type = 3'd1;
    e.we_wb = 1'b1; e.wb_sel = 2'd3; e.cmp_unsigned = 1'b1;
    send("sltiu", 32'h0011_3093, 32'h130, e);
    e = '0; e.pc = 32'h134; e.is_jal = 1'b1; e.muxa = 2'd1; e.muxb = 1'b1;
    e.imm_type = 3'd3; e.we_wb = 1'b1; e.wb_sel = 2'd1;
    send("jal", 32'h0080_00EF, 32'h134, e);
    e = '0; e.pc = 32'h138; e.trap = 1'b1; e.cause = 4'd2;
    send("ld_f3_3", 32'h0000_B103, 32'h138, e);
    neg();
    chk("illegal_load_hold", in_ready, 1'b0);
    cyc();
    do_flush();

    // flush with a held bundle and a word offered: word refused, bundle killed
    out_ready = 1'b0;
    e = '0; e.pc = 32'h200; e.muxb = 1'b1; e.imm_type = 3'd1; e.we_wb = 1'b1;
    send("held_addi", 32'h0050_0093, 32'h200, e);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h4020_8033; pc_in = 32'h204;
    neg();
    chk("flush_blocks_accept", in_ready, 1'b0);
    sb.delete();
    cyc();
    flush = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0;
    neg();
    chk("flush_kills_valid", out_valid, 1'b0);
    chk("flush_state_run", in_ready, 1'b1);
    out_ready = 1'b1;
    cyc();
    neg();
    chk("flush_no_accept", out_valid, 1'b0);
    cyc();

    // all-zero word traps; reset mid-hold discards everything
    out_ready = 1'b0;
    e = '0; e.pc = 32'h300; e.trap = 1'b1; e.cause = 4'd2;
    send("zero_word", 32'h0000_0000, 32'h300, e);
    neg();
    chk("zero_trap_cause", cause, 4'd2);
    chk("zero_trap_hold", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 1'b0);
    chk("async_reset_pc", pc_out, 32'h0);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    neg();
    chk("reset_releases_hold", in_ready, 1'b1);
    chk("reset_releases_nom", n_in_ready, 1'b1);
    cyc();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, parametrised decode/control stage for the XYZ core. It replaces purely combinational control generation with a pipelined ID stage. Each accepted instruction is decoded into a full control bundle, held in an output register under a valid/ready handshake, with flush support and a small sequencer that stalls issue behind multi-cycle MDU operations and pending traps. Branch resolution moves to EX: this stage forwards the branch condition code instead of the comparator result.

## Interface
- `ENABLE_M`, default 1: decode RV32M (mul/div group); when 0, those encodings are illegal.
- `ENABLE_ZICSR`, default 1: decode CSR instructions and `mret`; when 0, they are illegal.
- `CAUSE_W`, default 4: width of the trap cause field.

Ports:
- `clk_i`  in  1  — the single clock.
- `rst_ni`  in  1  — reset, asynchronous and active-low.
- `in_valid_i`  in  1  — IF has an instruction.
- `in_ready_o`  out  1  — stage accepts the instruction this cycle.
- `instr_i`  in  32  — instruction word.
- `pc_i`  in  32  — instruction PC.
- `flush_i`  in  1  — kill the held bundle and release any hold state.
- `mdu_done_i`  in  1  — EX multi-cycle op complete.
- `out_valid_o`  out  1  — bundle valid.
- `out_ready_i`  in  1  — EX consumes the bundle.
- `pc_o`  out  32  — PC of the held instruction.
- `alu_op_o`  out  4  — {sub/sra bit, funct3}.
- `muxa_o`  out  2  — operand A: 0 = rs1, 1 = PC, 2 = zero.
- `muxb_o`  out  1  — operand B: 0 = rs2, 1 = immediate.
- `muxcsr_o`  out  1  — CSR source: 0 = rs1, 1 = zimm.
- `imm_type_o`  out  3  — 0 U, 1 I, 2 B, 3 J, 4 S, 5 Z.
- `we_mem_o`, `is_ls_o`, `data_or_alu_o`, `we_wb_o`  out  1 each.
- `funct3_mem_o`  out  3  — memory access size/sign.
- `wb_sel_o`  out  2  — writeback source: 0 ALU/mem, 1 PC+4, 2 CSR, 3 compare.
- `csr_op_o`  out  2  — CSR operation, from instr[13:12].
- `is_csr_o`, `is_mret_o`, `is_mdu_o`  out  1 each.
- `is_branch_o`, `is_jal_o`, `is_jalr_o`  out  1 each.
- `br_cond_o`  out  3  — funct3 of the branch.
- `cmp_unsigned_o`  out  1  — sltu/sltiu.
- `trap_o`  out  1  — instruction raises a trap.
- `cause_o`  out  `CAUSE_W`  — trap cause code.

## Operation
- **Decode.**
  - Every bundle field defaults to 0 for every instruction class; the decoder has no latches and no don't-cares.
  - Trap causes: illegal = 2, ebreak = 3, ecall = 11.
  - Illegal covers: unknown opcode; funct7 mismatch on R-type or shift; load funct3 ∈ {3, 6, 7}; store funct3 > 2; branch funct3 ∈ {2, 3}; M/CSR encodings with the enable parameter at 0; and instr == 0.
  - 0x00000013 decodes as addi with `we_wb_o` = 1 and rd = x0.
  - fence decodes as a NOP bundle with `trap_o` = 0.
- **MDU ops** (funct7 = 0000001, opcode 0110011): `is_mdu_o` = 1, `alu_op_o` = {0, funct3}, `wb_sel_o` = 0.
- **Handshake.**
  - `in_ready_o` = (state == RUN) & ~flush_i & (~out_valid_o | out_ready_i).
  - Accept (`in_valid_i` & `in_ready_o`): load the bundle and `pc_o`, and set `out_valid_o`.
  - Drain without accept: clear `out_valid_o`.
  - Stall (`out_valid_o` & ~`out_ready_i`): the bundle holds bit-stable.
- **States:**
  - **RUN**
    - Goes to MDU_WAIT when an MDU bundle transfers (`out_valid_o` & `out_ready_i` & `is_mdu_o`).
    - Goes to TRAP_HOLD when a trapping instruction is accepted.
  - **MDU_WAIT**
    - No accepts.
    - Returns to RUN on `mdu_done_i` or `flush_i`.
  - **TRAP_HOLD**
    - No accepts.
    - The held trap bundle still drains normally.
    - Returns to RUN only on `flush_i`.
- **Flush.**
  - Priority: flush > accept > drain.
  - `out_valid_o` is 0 on the next edge and state returns to RUN.
  - The bundle fields may keep stale values, but only while `out_valid_o` = 0.
- `mdu_done_i` is ignored outside MDU_WAIT.

## Timing
- **Reset** (async, `rst_ni` low):
  - state = RUN.
  - `out_valid_o` = 0, every bundle output = 0, `pc_o` = 0.
  - `in_ready_o` = 1 after release, when `flush_i` = 0.
- **Latency:** one cycle from accept to `out_valid_o`. Full throughput, one instruction per cycle, when `out_ready_i` = 1.
- **MDU bubble:** after an MDU transfer at edge N, `in_ready_o` = 0 from cycle N+1 until the cycle after `mdu_done_i` is sampled.
- **Simultaneous events:**
  - `flush_i` with `mdu_done_i`: go to RUN.
  - `flush_i` with a trapping accept: the flush wins and TRAP_HOLD is not entered.
- **Reset mid-operation:** exits any state immediately; pending MDU or trap holds are discarded.

## Structure
- **`ctrl_pkg` contents:**
  - Opcode constants.
  - Cause codes.
  - Enums for imm_type, wb_sel, muxa, and the state (RUN, MDU_WAIT, TRAP_HOLD).
  - Packed struct `ctrl_bundle_t` holding all bundle fields.
- **Sub-module `rv_decoder`:** purely combinational, with inputs instr + parameters and output `ctrl_bundle_t`.
- **`ctrl_decode_stage` itself:** the handshake register and the FSM.

## Test plan
- Reset, then push addi x1,x0,5 (0x00500093) with out_ready_i = 1.
  - Next cycle: out_valid_o = 1, muxb_o = 1, imm_type_o = 1, we_wb_o = 1, alu_op_o = 0.
- Back-to-back sub (0x40208033), then add (0x002080B3), while EX stalls 2 cycles.
  - alu_op_o = 8 held stable, then alu_op_o = 0; no instruction is lost or duplicated.
- mul x3,x1,x2 (0x022081B3) with ENABLE_M = 1.
  - is_mdu_o = 1; after transfer, in_ready_o = 0 until mdu_done_i is pulsed; re-asserts next cycle.
- Same word with ENABLE_M = 0.
  - trap_o = 1, cause_o = 2, state TRAP_HOLD, in_ready_o = 0 until flush_i.
- ecall (0x00000073).
  - trap_o = 1, cause_o = 11.
- ebreak (0x00100073).
  - cause_o = 3.
- mret (0x30200073).
  - is_mret_o = 1, trap_o = 0.
- bgeu (0x0020F463).
  - is_branch_o = 1, br_cond_o = 7, imm_type_o = 2, we_wb_o = 0.
- flush_i asserted together with in_valid_i and a held bundle.
  - Next cycle: out_valid_o = 0, state RUN, and the incoming word is not accepted.
